// File: rtl/sw_arbiter_4.sv
// sw_arbiter_4: four-requester round-robin switch arbiter for one router output port.
// Drives the one-hot select of the downstream 4:1 output mux with a registered grant.
// With LOCK_EN set, a grant is held until the packet's tail flit transfers, so packets
// never interleave on the output. With LOCK_EN clear, arbitration happens on every flit.

module sw_arbiter_4 #(
    parameter bit LOCK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req_i,
    input  logic [3:0] tail_i,
    input  logic       fire_i,
    output logic [3:0] grant_o,
    output logic       grant_valid_o,
    output logic       locked_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01
    } state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [3:0] grant_q;
    logic       valid_q;
    logic       locked_q;

    // Round-robin search: first requester at or after ptr (mod 4).
    // Result is {found, onehot_grant}.
    function automatic logic [4:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [4:0] res;
        logic [1:0] idx;
        res = 5'b0;
        // Walk from the lowest-priority offset down so the highest-priority hit wins.
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + i[1:0];
            if (req[idx]) begin
                res = {1'b1, 4'b0001 << idx};
            end
        end
        return res;
    endfunction

    logic [1:0] grant_idx;
    logic       grant_ok;
    logic [1:0] rel_ptr;
    logic       release_now;
    logic [4:0] pick_idle;
    logic [4:0] pick_rel;

    // Decode the held grant into an index and flag any corrupted (non one-hot) value.
    always_comb begin
        grant_idx = 2'd0;
        grant_ok  = 1'b1;
        case (grant_q)
            4'b0001: grant_idx = 2'd0;
            4'b0010: grant_idx = 2'd1;
            4'b0100: grant_idx = 2'd2;
            4'b1000: grant_idx = 2'd3;
            default: grant_ok  = 1'b0;
        endcase
    end

    // Arbitration candidates: from the current pointer (IDLE) and from the pointer that
    // a release would install (zero-bubble handover in GRANT).
    always_comb begin
        rel_ptr     = grant_idx + 2'd1;
        release_now = !LOCK_EN || tail_i[grant_idx];
        pick_idle   = rr_pick(req_i, ptr_q);
        pick_rel    = rr_pick(req_i, rel_ptr);
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            ptr_q    <= 2'd0;
            grant_q  <= 4'b0000;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    locked_q <= 1'b0;
                    if (pick_idle[4]) begin
                        grant_q <= pick_idle[3:0];
                        valid_q <= 1'b1;
                        state_q <= StGrant;
                    end else begin
                        grant_q <= 4'b0000;
                        valid_q <= 1'b0;
                    end
                end

                StGrant: begin
                    if (!grant_ok) begin
                        // Corrupted grant: drop it rather than drive a multi-hot select.
                        grant_q  <= 4'b0000;
                        valid_q  <= 1'b0;
                        locked_q <= 1'b0;
                        state_q  <= StIdle;
                    end else if (fire_i) begin
                        if (release_now) begin
                            ptr_q    <= rel_ptr;
                            locked_q <= 1'b0;
                            if (pick_rel[4]) begin
                                grant_q <= pick_rel[3:0];
                                valid_q <= 1'b1;
                            end else begin
                                grant_q <= 4'b0000;
                                valid_q <= 1'b0;
                                state_q <= StIdle;
                            end
                        end else begin
                            locked_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    grant_q  <= 4'b0000;
                    valid_q  <= 1'b0;
                    locked_q <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = valid_q;
    assign locked_o      = locked_q;

endmodule
